// File: rtl/pe_pkg.sv
// Shared definitions for the processing-element MAC datapath: operand/product widths,
// accumulator defaults and the accumulator control states.
package pe_pkg;

  localparam int PE_OPND_W    = 12;
  localparam int PE_PROD_W    = 2 * PE_OPND_W;
  localparam int PE_ACC_W     = 32;
  localparam int PE_MAX_TERMS = 16;

  typedef enum logic {
    ACC,
    HOLD
  } pe_state_e;

endpackage

// File: rtl/pe_mac_accumulator_if.sv
// Product-in / result-out handshake bundle between the Booth multiplier, the MAC
// accumulator stage and the result consumer.
interface pe_mac_accumulator_if
  import pe_pkg::*;
#(
  parameter int PROD_W = PE_PROD_W,
  parameter int ACC_W  = PE_ACC_W,
  parameter int CNT_W  = $clog2(PE_MAX_TERMS) + 1
);

  logic              in_valid;
  logic              in_ready;
  logic [PROD_W-1:0] in_product;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_sum;
  logic [CNT_W-1:0]  out_terms;
  logic              out_ovf;
  logic              out_forced;

  modport master (
    output in_valid, in_product, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_terms, out_ovf, out_forced
  );

  modport slave (
    input  in_valid, in_product, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_terms, out_ovf, out_forced
  );

endinterface

// File: rtl/pe_acc_adder.sv
// Combinational accumulate step: (clear ? 0 : acc) + zero-extended product with carry-out.
// Defining PE_ACC_SAT_EN clamps the result to all ones on overflow instead of wrapping.
module pe_acc_adder
  import pe_pkg::*;
#(
  parameter int PROD_W = PE_PROD_W,
  parameter int ACC_W  = PE_ACC_W
) (
  input  logic [ACC_W-1:0]  acc_i,
  input  logic              clear_i,
  input  logic [PROD_W-1:0] product_i,
  output logic [ACC_W-1:0]  sum_o,
  output logic              ovf_o
);

  logic [ACC_W-1:0] base;
  logic [ACC_W:0]   raw;

  assign base  = clear_i ? '0 : acc_i;
  assign raw   = {1'b0, base} + {{(ACC_W + 1 - PROD_W){1'b0}}, product_i};
  assign ovf_o = raw[ACC_W];

  // Once clamped, any further nonzero term overflows again, so the clamp holds for the run.
`ifdef PE_ACC_SAT_EN
  assign sum_o = raw[ACC_W] ? '1 : raw[ACC_W-1:0];
`else
  assign sum_o = raw[ACC_W-1:0];
`endif

endmodule

// File: rtl/pe_mac_accumulator.sv
// Sequential MAC back end: accumulates runs of unsigned products and presents one
// registered dot-product result per run. Saturation is selected by PE_ACC_SAT_EN.
module pe_mac_accumulator
  import pe_pkg::*;
#(
  parameter int PROD_W    = PE_PROD_W,
  parameter int ACC_W     = PE_ACC_W,
  parameter int MAX_TERMS = PE_MAX_TERMS,
  parameter int CNT_W     = $clog2(MAX_TERMS) + 1
) (
  input logic                 clk,
  input logic                 rst_n,
  pe_mac_accumulator_if.slave bus
);

  pe_state_e        state_q;
  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] acc_d;
  logic [ACC_W-1:0] out_sum_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_base;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] out_terms_q;
  logic             ovf_q;
  logic             ovf_d;
  logic             add_ovf;
  logic             first_q;
  logic             in_hold;
  logic             accept;
  logic             close;
  logic             out_valid_q;
  logic             out_ovf_q;
  logic             out_forced_q;

  // A beat taken while in HOLD starts a fresh run, so the old run's count/ovf are masked.
  assign in_hold      = (state_q == HOLD);
  assign bus.in_ready = !in_hold || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;
  assign cnt_base     = in_hold ? '0 : cnt_q;
  assign cnt_d        = cnt_base + CNT_W'(1);
  assign ovf_d        = (!in_hold && ovf_q) || add_ovf;
  assign close        = bus.in_last || (cnt_base == CNT_W'(MAX_TERMS - 1));

  pe_acc_adder #(
    .PROD_W (PROD_W),
    .ACC_W  (ACC_W)
  ) u_adder (
    .acc_i     (acc_q),
    .clear_i   (first_q || in_hold),
    .product_i (bus.in_product),
    .sum_o     (acc_d),
    .ovf_o     (add_ovf)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ACC;
      acc_q        <= '0;
      cnt_q        <= '0;
      ovf_q        <= 1'b0;
      first_q      <= 1'b1;
      out_valid_q  <= 1'b0;
      out_sum_q    <= '0;
      out_terms_q  <= '0;
      out_ovf_q    <= 1'b0;
      out_forced_q <= 1'b0;
    end else if (accept) begin
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      first_q <= 1'b0;
      if (close) begin
        out_sum_q    <= acc_d;
        out_terms_q  <= cnt_d;
        out_ovf_q    <= ovf_d;
        out_forced_q <= !bus.in_last;
        out_valid_q  <= 1'b1;
        state_q      <= HOLD;
      end else begin
        out_valid_q <= 1'b0;
        state_q     <= ACC;
      end
    end else if (in_hold && bus.out_ready) begin
      out_valid_q <= 1'b0;
      state_q     <= ACC;
      first_q     <= 1'b1;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
    end
  end

  assign bus.out_valid  = out_valid_q;
  assign bus.out_sum    = out_sum_q;
  assign bus.out_terms  = out_terms_q;
  assign bus.out_ovf    = out_ovf_q;
  assign bus.out_forced = out_forced_q;

endmodule

// File: tb/tb_pe_mac_accumulator.sv
// Directed bench for pe_mac_accumulator: default build, a MAX_TERMS=4 build and an
// ACC_W=24 build; expectations follow PE_ACC_SAT_EN when it is defined.
module tb_pe_mac_accumulator;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  pe_mac_accumulator_if #(.PROD_W(24), .ACC_W(32), .CNT_W(5)) ifA ();
  pe_mac_accumulator_if #(.PROD_W(24), .ACC_W(32), .CNT_W(3)) ifB ();
  pe_mac_accumulator_if #(.PROD_W(24), .ACC_W(24), .CNT_W(5)) ifC ();

  pe_mac_accumulator dutA (.clk(clk), .rst_n(rst_n), .bus(ifA));

  pe_mac_accumulator #(.MAX_TERMS(4)) dutB (.clk(clk), .rst_n(rst_n), .bus(ifB));

  pe_mac_accumulator #(.ACC_W(24)) dutC (.clk(clk), .rst_n(rst_n), .bus(ifC));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    ifA.in_valid = 0; ifA.in_product = '0; ifA.in_last = 0; ifA.out_ready = 0;
    ifB.in_valid = 0; ifB.in_product = '0; ifB.in_last = 0; ifB.out_ready = 0;
    ifC.in_valid = 0; ifC.in_product = '0; ifC.in_last = 0; ifC.out_ready = 0;
    repeat (2) applyStimulus();

    checkOutput("rst_valid", ifA.out_valid, 0);
    checkOutput("rst_sum", ifA.out_sum, 0);
    checkOutput("rst_ready", ifA.in_ready, 1);
    rst_n = 1'b1;

    // Two beats into a run, then an asynchronous reset between clock edges.
    ifA.in_valid = 1; ifA.in_product = 24'h5;
    applyStimulus();
    ifA.in_product = 24'h6;
    applyStimulus();
    checkOutput("midrun_valid", ifA.out_valid, 0);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_valid", ifA.out_valid, 0);
    checkOutput("midrst_sum", ifA.out_sum, 0);
    checkOutput("midrst_terms", ifA.out_terms, 0);
    checkOutput("midrst_ovf", ifA.out_ovf, 0);
    checkOutput("midrst_forced", ifA.out_forced, 0);
    checkOutput("midrst_ready", ifA.in_ready, 1);
    rst_n = 1'b1;
    ifA.in_product = 24'h9; ifA.in_last = 1;
    applyStimulus();
    checkOutput("postrst_valid", ifA.out_valid, 1);
    checkOutput("postrst_sum", ifA.out_sum, 32'h9);
    checkOutput("postrst_terms", ifA.out_terms, 1);
    ifA.in_valid = 0; ifA.in_last = 0; ifA.out_ready = 1;
    applyStimulus();
    checkOutput("drain_valid", ifA.out_valid, 0);

    // Three full-scale products, closed by in_last.
    ifA.in_valid = 1; ifA.in_product = 24'hFFE001; ifA.in_last = 0;
    applyStimulus();
    applyStimulus();
    checkOutput("three_pre_valid", ifA.out_valid, 0);
    ifA.in_last = 1;
    applyStimulus();
    checkOutput("three_valid", ifA.out_valid, 1);
    checkOutput("three_sum", ifA.out_sum, 32'h2FFA003);
    checkOutput("three_terms", ifA.out_terms, 3);
    checkOutput("three_ovf", ifA.out_ovf, 0);
    checkOutput("three_forced", ifA.out_forced, 0);

    // Consumer stalls while a beat waits: no acceptance, stable outputs.
    ifA.out_ready = 0; ifA.in_product = 24'h123; ifA.in_last = 1;
    for (int i = 0; i < 5; i++) begin
      applyStimulus();
      checkOutput("stall_ready", ifA.in_ready, 0);
      checkOutput("stall_valid", ifA.out_valid, 1);
      checkOutput("stall_sum", ifA.out_sum, 32'h2FFA003);
      checkOutput("stall_terms", ifA.out_terms, 3);
    end
    ifA.out_ready = 1; ifA.in_product = 24'h7;
    #1;
    checkOutput("release_ready", ifA.in_ready, 1);
    applyStimulus();
    checkOutput("single_valid", ifA.out_valid, 1);
    checkOutput("single_sum", ifA.out_sum, 32'h7);
    checkOutput("single_terms", ifA.out_terms, 1);

    // Back-to-back single-term runs, one result per cycle.
    for (int i = 1; i <= 3; i++) begin
      ifA.in_product = 24'(i);
      applyStimulus();
      checkOutput("b2b_valid", ifA.out_valid, 1);
      checkOutput("b2b_sum", ifA.out_sum, 64'(i));
      checkOutput("b2b_terms", ifA.out_terms, 1);
    end

    // Zero products still count as terms.
    ifA.in_product = 24'h0; ifA.in_last = 0;
    applyStimulus();
    checkOutput("zero_mid_valid", ifA.out_valid, 0);
    applyStimulus();
    ifA.in_product = 24'h5; ifA.in_last = 1;
    applyStimulus();
    checkOutput("zero_sum", ifA.out_sum, 32'h5);
    checkOutput("zero_terms", ifA.out_terms, 3);
    ifA.in_valid = 0; ifA.in_last = 0;
    applyStimulus();

    // MAX_TERMS=4: forced close, then the next run keeps going.
    ifB.out_ready = 1; ifB.in_valid = 1; ifB.in_product = 24'h10; ifB.in_last = 0;
    repeat (4) applyStimulus();
    checkOutput("force_valid", ifB.out_valid, 1);
    checkOutput("force_sum", ifB.out_sum, 32'h40);
    checkOutput("force_terms", ifB.out_terms, 4);
    checkOutput("force_flag", ifB.out_forced, 1);
    checkOutput("force_ovf", ifB.out_ovf, 0);
    applyStimulus();
    checkOutput("force_next_valid", ifB.out_valid, 0);
    applyStimulus();
    ifB.in_last = 1;
    applyStimulus();
    checkOutput("cont_valid", ifB.out_valid, 1);
    checkOutput("cont_sum", ifB.out_sum, 32'h30);
    checkOutput("cont_terms", ifB.out_terms, 3);
    checkOutput("cont_forced", ifB.out_forced, 0);
    ifB.in_valid = 0; ifB.in_last = 0;

    // ACC_W=24 overflow: wrap by default, clamp when saturating.
    ifC.out_ready = 1; ifC.in_valid = 1; ifC.in_product = 24'hFFE001; ifC.in_last = 0;
    applyStimulus();
    ifC.in_last = 1;
    applyStimulus();
    checkOutput("ovf_valid", ifC.out_valid, 1);
`ifdef PE_ACC_SAT_EN
    checkOutput("ovf_sum", ifC.out_sum, 24'hFFFFFF);
`else
    checkOutput("ovf_sum", ifC.out_sum, 24'hFFC002);
`endif
    checkOutput("ovf_flag", ifC.out_ovf, 1);
    checkOutput("ovf_terms", ifC.out_terms, 2);
    ifC.in_valid = 0; ifC.in_last = 0;
    applyStimulus();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
